// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter/rotator: splits a 0..31 shift distance into steps of at most
// 2^StepBits-1 positions, the first step taken on the accepting edge.
module shift_sequencer #(
    parameter int DataWidth = 32,
    parameter int StepBits  = 3
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Start,
    input  logic [2:0]           Mode,
    input  logic [DataWidth-1:0] DataA,
    input  logic [4:0]           ShiftAmount,
    output logic                 Busy,
    output logic                 Done,
    output logic [DataWidth-1:0] Result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] MaxStep = 5'((1 << StepBits) - 1);

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   acc_q, acc_d;
    logic [4:0]             rem_q, rem_d;
    logic [2:0]             mode_q, mode_d;
    logic [DataWidth-1:0]   result_q, result_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   pass_thru;
    logic [DataWidth-1:0]   src_acc;
    logic [4:0]             src_rem;
    logic [2:0]             src_mode;
    logic [4:0]             step;
    logic [DataWidth-1:0]   nxt_acc;
    logic [4:0]             nxt_rem;

    // One narrow shift stage; rotates use a doubled word so bits wrap through the other end.
    function automatic logic [DataWidth-1:0] shift_step(
        input logic [2:0]           m,
        input logic [DataWidth-1:0] a,
        input logic [4:0]           s
    );
        logic [2*DataWidth-1:0] dbl;
        dbl = {a, a};
        case (m)
            3'd0: shift_step = a << s;
            3'd1: begin
                dbl        = dbl << s;
                shift_step = dbl[2*DataWidth-1:DataWidth];
            end
            3'd2: shift_step = a >> s;
            3'd3: shift_step = DataWidth'($signed(a) >>> s);
            3'd4: begin
                dbl        = dbl >> s;
                shift_step = dbl[DataWidth-1:0];
            end
            default: shift_step = a;
        endcase
    endfunction

    function automatic logic [4:0] step_of(input logic [4:0] r);
        step_of = (r > MaxStep) ? MaxStep : r;
    endfunction

    always_comb begin
        accept    = Start && (state_q != SHIFT);
        pass_thru = (ShiftAmount == 5'd0) || (Mode > 3'd4);

        src_acc  = accept ? DataA       : acc_q;
        src_rem  = accept ? ShiftAmount : rem_q;
        src_mode = accept ? Mode        : mode_q;
        step     = step_of(src_rem);
        nxt_acc  = shift_step(src_mode, src_acc, step);
        nxt_rem  = src_rem - step;

        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        result_d = result_q;

        if (accept && pass_thru) begin
            acc_d    = DataA;
            rem_d    = ShiftAmount;
            mode_d   = Mode;
            result_d = DataA;
            state_d  = DONE;
        end else if (accept || (state_q == SHIFT)) begin
            acc_d  = nxt_acc;
            rem_d  = nxt_rem;
            mode_d = src_mode;
            if (nxt_rem == 5'd0) begin
                result_d = nxt_acc;
                state_d  = DONE;
            end else begin
                state_d  = SHIFT;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and randomized operations checked against a bitwise
// whole-distance reference model and a closed-form latency.
module tb_shift_sequencer;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Mode = 3'd0;
    logic [31:0] DataA = 32'd0;
    logic [4:0]  ShiftAmount = 5'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_exp = 32'd0;

    shift_sequencer #(.DataWidth(32), .StepBits(3)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .Mode(Mode),
        .DataA(DataA), .ShiftAmount(ShiftAmount),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 Clock = ~Clock;

    // Result bit i is taken straight from its source bit for the whole distance at once.
    function automatic logic [31:0] ref_shift(input logic [2:0] m, input logic [31:0] a,
                                              input int amt);
        logic [31:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (m)
                3'd0: begin src = i - amt; r[i] = (src >= 0) ? a[5'(src)] : 1'b0; end
                3'd1: begin src = (i - amt + 32) % 32; r[i] = a[5'(src)]; end
                3'd2: begin src = i + amt; r[i] = (src < 32) ? a[5'(src)] : 1'b0; end
                3'd3: begin src = i + amt; r[i] = (src < 32) ? a[5'(src)] : a[31]; end
                3'd4: begin src = (i + amt) % 32; r[i] = a[5'(src)]; end
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] m, input int amt);
        if (amt == 0 || m > 3'd4) return 1;
        return (amt + 6) / 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Applies one operation at a negedge; optionally hammers Start with junk while busy.
    task automatic do_op(input logic [2:0] m, input logic [31:0] a, input logic [4:0] amt,
                         input bit scramble);
        logic [31:0] exp;
        logic [31:0] held;
        int lat;
        int edges;
        bit got;
        exp   = ref_shift(m, a, int'(amt));
        lat   = ref_latency(m, int'(amt));
        @(negedge Clock);
        held        = Result;
        Mode        = m;
        DataA       = a;
        ShiftAmount = amt;
        Start       = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge Clock);
            #1;
            edges++;
            if (Done === 1'b1) begin
                got = 1'b1;
            end else begin
                check("busy_while_shifting", {31'd0, Busy}, 32'd1);
                check("result_stable_busy", Result, held);
                @(negedge Clock);
                Start = scramble;
                if (scramble) begin
                    Mode        = 3'($urandom_range(0, 7));
                    DataA       = $urandom;
                    ShiftAmount = 5'($urandom_range(0, 31));
                end
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", 32'(edges), 32'(lat));
        check("busy_low_at_done", {31'd0, Busy}, 32'd0);
        check("result", Result, exp);
        last_exp = exp;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            Start = 1'b0;
            @(posedge Clock);
            #1;
            check("idle_done_low", {31'd0, Done}, 32'd0);
            check("idle_busy_low", {31'd0, Busy}, 32'd0);
            check("idle_result_held", Result, last_exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_result", Result, 32'd0);
        @(negedge Clock);
        ResetN = 1'b1;
        idle(2);

        do_op(3'd0, 32'h0000_0001, 5'd31, 1'b0);
        check("sll31_const", Result, 32'h8000_0000);
        idle(1);
        do_op(3'd3, 32'h8000_0000, 5'd4, 1'b0);
        check("sra4_const", Result, 32'hF800_0000);
        idle(1);
        do_op(3'd2, 32'h8000_0000, 5'd4, 1'b0);
        check("srl4_const", Result, 32'h0800_0000);
        idle(1);
        do_op(3'd4, 32'h0000_00F1, 5'd8, 1'b0);
        check("ror8_const", Result, 32'hF100_0000);
        idle(1);
        do_op(3'd1, 32'h8000_0001, 5'd1, 1'b0);
        check("rol1_const", Result, 32'h0000_0003);
        idle(1);
        do_op(3'd2, 32'h1234_5678, 5'd0, 1'b0);
        check("zero_amt_const", Result, 32'h1234_5678);
        idle(1);
        do_op(3'd6, 32'hCAFE_F00D, 5'd9, 1'b0);
        check("passthru_const", Result, 32'hCAFE_F00D);
        idle(1);

        // Start hammered during busy is ignored; then back-to-back ops out of DONE.
        do_op(3'd0, 32'h0000_0001, 5'd31, 1'b1);
        check("ignored_start_const", Result, 32'h8000_0000);
        do_op(3'd4, 32'h0000_00F1, 5'd8, 1'b0);
        do_op(3'd7, 32'h0BAD_BEEF, 5'd3, 1'b0);
        do_op(3'd3, 32'h8765_4321, 5'd15, 1'b0);
        idle(2);

        // Async reset in the middle of a 31-position SLL.
        @(negedge Clock);
        Mode = 3'd0; DataA = 32'h0000_0001; ShiftAmount = 5'd31; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        @(posedge Clock);
        #1;
        check("mid_op_busy", {31'd0, Busy}, 32'd1);
        #1 ResetN = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, Busy}, 32'd0);
        check("async_rst_done", {31'd0, Done}, 32'd0);
        check("async_rst_result", Result, 32'd0);
        #1 ResetN = 1'b1;
        last_exp = 32'd0;
        idle(8);
        do_op(3'd3, 32'hFFFF_FF00, 5'd8, 1'b0);
        check("post_rst_sra_const", Result, 32'hFFFF_FFFF);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                  bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
